// File: rtl/ascon_perm_engine.sv
// Iterative ASCON permutation p^a (a = 12, 8, 6) over a 320-bit state, UNROLL rounds per clock.
// Optional `ASCON_PERM_BYPASS_EN: mode 2'b11 becomes a zero-round pass-through instead of p12.
package ascon_perm_pkg;
  typedef logic [4:0][63:0] type_state;  // index i holds lane xi
endpackage

module ascon_perm_engine
  import ascon_perm_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] round_o
);

  generate
    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
      $error("ascon_perm_engine: UNROLL must be 1 or 2");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t      fsm_q, fsm_d;
  type_state state_q, state_d;
  type_state step_state;
  logic [3:0] round_q, round_d;
  logic [3:0] first_round;
  logic       done_q, done_d;
  logic       last_step;
  logic       bypass_run;

  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One full round: constant on x2[7:0], bit-sliced S-box, linear diffusion.
  // NOTE: blocking assignments here build a combinational chain of temporaries;
  // registered state is only ever written with <= inside always_ff.
  function automatic type_state ascon_round(input type_state s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    type_state o;
    x0 = s[0]; x1 = s[1]; x2 = s[2] ^ {56'd0, ~r, r}; x3 = s[3]; x4 = s[4];
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    o[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    o[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return o;
  endfunction

  generate
    if (UNROLL == 2) begin : g_unroll2
      assign step_state = ascon_round(ascon_round(state_q, round_q), round_q + 4'd1);
    end else begin : g_unroll1
      assign step_state = ascon_round(state_q, round_q);
    end
  endgenerate

  // p^a starts at round 12-a; round index 12 marks "nothing left to apply".
  always_comb begin
    unique case (mode_i)
      2'b00:   first_round = 4'd0;
      2'b01:   first_round = 4'd4;
      2'b10:   first_round = 4'd6;
`ifdef ASCON_PERM_BYPASS_EN
      default: first_round = 4'd12;
`else
      default: first_round = 4'd0;
`endif
    endcase
  end

  assign last_step = ({1'b0, round_q} + 5'(UNROLL)) >= 5'd12;
`ifdef ASCON_PERM_BYPASS_EN
  assign bypass_run = (round_q == 4'd12);
`else
  assign bypass_run = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    done_d  = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (start_i) begin
          fsm_d   = RUN;
          state_d = state_i;
          round_d = first_round;
        end
      end
      RUN: begin
        if (bypass_run) begin
          fsm_d  = IDLE;
          done_d = 1'b1;
        end else if (last_step) begin
          fsm_d   = IDLE;
          state_d = step_state;
          round_d = 4'd12;
          done_d  = 1'b1;
        end else begin
          state_d = step_state;
          round_d = round_q + 4'(UNROLL);
        end
      end
    endcase
  end

  // NOTE: the 320-bit state register is reset too, since state_o must read zero out of reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= 4'd12;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign state_o = state_q;
  assign busy_o  = (fsm_q == RUN);
  assign done_o  = done_q;
  assign round_o = round_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Self-checking bench for ascon_perm_engine: UNROLL=1 and UNROLL=2 instances, table-driven S-box model,
// scoreboard queues filled at launch and drained on done_o.
module tb_ascon_perm_engine;
  import ascon_perm_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [1:0]           start_v;
  logic [1:0][1:0]      mode_v;
  type_state [1:0]      st_in_v;
  type_state [1:0]      st_out_v;
  logic [1:0]           busy_v, done_v;
  logic [1:0][3:0]      round_v;

  int n_checks = 0;
  int n_fails  = 0;
  type_state sb_q0[$];
  type_state sb_q1[$];

  localparam logic [4:0] SBOX [0:31] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  always #5 clock = ~clock;

  ascon_perm_engine #(.UNROLL(1)) u_dut1 (
    .clock_i(clock), .reset_i(reset), .start_i(start_v[0]), .mode_i(mode_v[0]),
    .state_i(st_in_v[0]), .state_o(st_out_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]),
    .round_o(round_v[0]));

  ascon_perm_engine #(.UNROLL(2)) u_dut2 (
    .clock_i(clock), .reset_i(reset), .start_i(start_v[1]), .mode_i(mode_v[1]),
    .state_i(st_in_v[1]), .state_o(st_out_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]),
    .round_o(round_v[1]));

  // ---------------- golden model ----------------
  function automatic logic [63:0] rot(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic type_state model_round(input type_state s, input int r);
    type_state t;
    logic [4:0] col, o;
    logic [7:0] c;
    c = 8'((15 - r) * 16 + r);
    s[2][7:0] = s[2][7:0] ^ c;
    for (int b = 0; b < 64; b++) begin
      col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
      o = SBOX[col];
      t[0][b] = o[4]; t[1][b] = o[3]; t[2][b] = o[2]; t[3][b] = o[1]; t[4][b] = o[0];
    end
    s[0] = t[0] ^ rot(t[0], 19) ^ rot(t[0], 28);
    s[1] = t[1] ^ rot(t[1], 61) ^ rot(t[1], 39);
    s[2] = t[2] ^ rot(t[2], 1)  ^ rot(t[2], 6);
    s[3] = t[3] ^ rot(t[3], 10) ^ rot(t[3], 17);
    s[4] = t[4] ^ rot(t[4], 7)  ^ rot(t[4], 41);
    return s;
  endfunction

  function automatic type_state model_perm(input type_state s, input int a);
    for (int r = 12 - a; r < 12; r++) s = model_round(s, r);
    return s;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
    return s;
  endfunction

  // ---------------- scoreboard ----------------
  function automatic void sb_push(input int u, input type_state v);
    if (u == 0) sb_q0.push_back(v);
    else sb_q1.push_back(v);
  endfunction

  function automatic type_state sb_pop(input int u);
    if (u == 0) return (sb_q0.size() != 0) ? sb_q0.pop_front() : 'x;
    return (sb_q1.size() != 0) ? sb_q1.pop_front() : 'x;
  endfunction

  // Drives a start on instance u; a = rounds expected (0 = bypass). Returns just after E0.
  task automatic launch(input int u, input logic [1:0] m, input type_state s, input int a,
                        input bit keep_start);
    @(negedge clock);
    mode_v[u] = m; st_in_v[u] = s; start_v[u] = 1'b1;
    sb_push(u, (a > 0) ? model_perm(s, a) : s);
    @(posedge clock);
    #1;
    if (!keep_start) begin
      start_v[u] = 1'b0;
      mode_v[u]  = 2'b11;
      st_in_v[u] = rand_state();
    end
  endtask

  // Counts edges after E0 until done_o is seen (edges = -1 if the budget expires).
  task automatic wait_done(input int u, input int budget, output int edges, output int busy_cnt);
    edges = 0; busy_cnt = 0;
    forever begin
      @(negedge clock);
      if (busy_v[u]) busy_cnt++;
      if (done_v[u]) return;
      if (edges >= budget) begin edges = -1; return; end
      @(posedge clock);
      edges++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3 reset = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (st_out_v[u] !== '0 || busy_v[u] !== 1'b0 || done_v[u] !== 1'b0 || round_v[u] !== 4'd12) begin
        n_fails++;
        $display("FAIL reset_async_u%0d: state=%h busy=%b done=%b round=%0d, want 0/0/0/12",
                 u, st_out_v[u], busy_v[u], done_v[u], round_v[u]);
      end
    end
    @(negedge clock); reset = 1'b0;
    repeat (3) @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (st_out_v[u] !== '0 || busy_v[u] !== 1'b0 || done_v[u] !== 1'b0 || round_v[u] !== 4'd12) begin
        n_fails++;
        $display("FAIL reset_idle_u%0d: state=%h busy=%b done=%b round=%0d, want 0/0/0/12",
                 u, st_out_v[u], busy_v[u], done_v[u], round_v[u]);
      end
    end
  endtask

  task automatic test_p12_unroll1();
    int edges, busy_cnt;
    logic [3:0] r1;
    type_state s1, exp_s;
    launch(0, 2'b00, '0, 12, 1'b0);
    fork
      wait_done(0, 20, edges, busy_cnt);
      begin @(posedge clock); @(negedge clock); r1 = round_v[0]; s1 = st_out_v[0]; end
    join
    n_checks++;
    if (r1 !== 4'd1) begin n_fails++; $display("FAIL p12_e1_round: got %0d want 1", r1); end
    exp_s = model_round('0, 0);
    n_checks++;
    if (s1 !== exp_s) begin n_fails++; $display("FAIL p12_e1_state: got %h want %h", s1, exp_s); end
    n_checks++;
    if (edges != 12 || busy_cnt != 12) begin
      n_fails++; $display("FAIL p12_timing: done edge %0d busy cycles %0d, want 12 and 12", edges, busy_cnt);
    end
    exp_s = sb_pop(0);
    n_checks++;
    if (st_out_v[0] !== exp_s || round_v[0] !== 4'd12) begin
      n_fails++; $display("FAIL p12_result: got %h round %0d want %h round 12", st_out_v[0], round_v[0], exp_s);
    end
    @(negedge clock);
    n_checks++;
    if (done_v[0] !== 1'b0 || st_out_v[0] !== exp_s) begin
      n_fails++; $display("FAIL p12_done_pulse: done=%b state=%h, want done=0 state held", done_v[0], st_out_v[0]);
    end
  endtask

  task automatic test_unroll2();
    int edges, busy_cnt, a;
    logic [3:0] r1;
    type_state s, s1, exp_s;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? 6 : 8;
      s = rand_state();
      launch(1, (k == 0) ? 2'b10 : 2'b01, s, a, 1'b0);
      fork
        wait_done(1, 20, edges, busy_cnt);
        begin @(posedge clock); @(negedge clock); r1 = round_v[1]; s1 = st_out_v[1]; end
      join
      n_checks++;
      if (r1 !== 4'(14 - a)) begin n_fails++; $display("FAIL u2_p%0d_e1_round: got %0d want %0d", a, r1, 14 - a); end
      exp_s = model_round(model_round(s, 12 - a), 13 - a);
      n_checks++;
      if (s1 !== exp_s) begin n_fails++; $display("FAIL u2_p%0d_e1_state: got %h want %h", a, s1, exp_s); end
      n_checks++;
      if (edges != a / 2) begin n_fails++; $display("FAIL u2_p%0d_timing: done edge %0d want %0d", a, edges, a / 2); end
      exp_s = sb_pop(1);
      n_checks++;
      if (st_out_v[1] !== exp_s) begin n_fails++; $display("FAIL u2_p%0d_result: got %h want %h", a, st_out_v[1], exp_s); end
    end
  endtask

  task automatic test_ignored_start();
    int edges, busy_cnt;
    type_state exp_s;
    launch(0, 2'b00, rand_state(), 12, 1'b0);
    fork
      wait_done(0, 20, edges, busy_cnt);
      begin
        @(posedge clock); @(posedge clock); @(negedge clock);
        start_v[0] = 1'b1; mode_v[0] = 2'b01; st_in_v[0] = rand_state();
        @(posedge clock); #1 start_v[0] = 1'b0;
      end
    join
    n_checks++;
    if (edges != 12) begin n_fails++; $display("FAIL ignored_start_timing: done edge %0d want 12", edges); end
    exp_s = sb_pop(0);
    n_checks++;
    if (st_out_v[0] !== exp_s) begin n_fails++; $display("FAIL ignored_start_result: got %h want %h", st_out_v[0], exp_s); end
  endtask

  task automatic test_back_to_back();
    int edges, busy_cnt;
    type_state b, exp_s;
    launch(0, 2'b10, rand_state(), 6, 1'b1);
    wait_done(0, 20, edges, busy_cnt);
    n_checks++;
    if (edges != 6) begin n_fails++; $display("FAIL b2b_first_timing: done edge %0d want 6", edges); end
    exp_s = sb_pop(0);
    n_checks++;
    if (st_out_v[0] !== exp_s) begin n_fails++; $display("FAIL b2b_first_result: got %h want %h", st_out_v[0], exp_s); end
    b = rand_state();
    st_in_v[0] = b;
    sb_push(0, model_perm(b, 6));
    @(posedge clock); #1 start_v[0] = 1'b0;
    n_checks++;
    if (busy_v[0] !== 1'b1 || round_v[0] !== 4'd6) begin
      n_fails++; $display("FAIL b2b_restart: busy=%b round=%0d want busy=1 round=6", busy_v[0], round_v[0]);
    end
    wait_done(0, 20, edges, busy_cnt);
    n_checks++;
    if (edges != 6) begin n_fails++; $display("FAIL b2b_second_timing: done edge %0d want 6", edges); end
    exp_s = sb_pop(0);
    n_checks++;
    if (st_out_v[0] !== exp_s) begin n_fails++; $display("FAIL b2b_second_result: got %h want %h", st_out_v[0], exp_s); end
  endtask

  task automatic test_reset_mid();
    int edges, busy_cnt, done_seen;
    type_state exp_s;
    done_seen = 0;
    launch(0, 2'b00, rand_state(), 12, 1'b0);
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (st_out_v[0] !== '0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || round_v[0] !== 4'd12) begin
      n_fails++; $display("FAIL reset_mid_values: state=%h busy=%b done=%b round=%0d want 0/0/0/12",
                          st_out_v[0], busy_v[0], done_v[0], round_v[0]);
    end
    sb_q0.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (12) begin @(negedge clock); if (done_v[0]) done_seen++; end
    n_checks++;
    if (done_seen != 0) begin n_fails++; $display("FAIL reset_mid_no_done: saw %0d done pulses want 0", done_seen); end
    launch(0, 2'b00, rand_state(), 12, 1'b0);
    wait_done(0, 20, edges, busy_cnt);
    n_checks++;
    if (edges != 12) begin n_fails++; $display("FAIL reset_mid_rerun_timing: done edge %0d want 12", edges); end
    exp_s = sb_pop(0);
    n_checks++;
    if (st_out_v[0] !== exp_s) begin n_fails++; $display("FAIL reset_mid_rerun_result: got %h want %h", st_out_v[0], exp_s); end
  endtask

  task automatic test_mode11();
    int edges, busy_cnt, a, want_edges;
    type_state s, exp_s;
    for (int i = 0; i < 5; i++) s[i] = 64'h0123_4567_89ab_cdef + 64'(i);
    for (int u = 0; u < 2; u++) begin
`ifdef ASCON_PERM_BYPASS_EN
      a = 0; want_edges = 1;
`else
      a = 12; want_edges = 12 / (u + 1);
`endif
      launch(u, 2'b11, s, a, 1'b0);
      wait_done(u, 20, edges, busy_cnt);
      n_checks++;
      if (edges != want_edges) begin
        n_fails++; $display("FAIL mode11_u%0d_timing: done edge %0d want %0d", u, edges, want_edges);
      end
      exp_s = sb_pop(u);
      n_checks++;
      if (st_out_v[u] !== exp_s || round_v[u] !== 4'd12) begin
        n_fails++; $display("FAIL mode11_u%0d_result: got %h round %0d want %h round 12",
                            u, st_out_v[u], round_v[u], exp_s);
      end
    end
  endtask

  initial begin
    start_v = '0; mode_v = '0; st_in_v = '0;
    test_reset();
    test_p12_unroll1();
    test_unroll2();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_mode11();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ascon_perm_engine.md
# ascon_perm_engine

Iterative ASCON permutation engine: applies p^a (a = 12, 8 or 6 rounds) to a 320-bit state.
- Each round is constant addition, then 5-bit S-box substitution, then linear diffusion.
- Constant addition is generalised here to a run-time start round and a configurable number of rounds per cycle.
- Sits between the mode FSM and the state register in the top-level cipher; the FSM drives `start_i` and waits on `done_o`.

## Interface
Parameters:
- `UNROLL`, default 1: rounds applied per clock edge; legal values 1 or 2, since both divide 12, 8 and 6. Any other value is an elaboration error.

Ports:
- `clock_i`: input, 1 bit. Single clock, rising edge.
- `reset_i`: input, 1 bit. Asynchronous, active-high reset.
- `start_i`: input, 1 bit. Request a permutation; accepted only when `busy_o` is 0.
- `mode_i`: input, 2 bits. Round count: 00 selects p12, 01 selects p8, 10 selects p6, 11 see Configuration. Sampled with `start_i`.
- `state_i`: input, `type_state` (5 x 64). Input state x0..x4. Sampled with `start_i`.
- `state_o`: output, `type_state`. State register contents; holds the final result after `done_o`.
- `busy_o`: output, 1 bit. Permutation in progress.
- `done_o`: output, 1 bit. One-cycle pulse when the result is valid.
- `round_o`: output, 4 bits. Index of the next round to apply (0..12).

## Operation
- Round constant for round r (0..11) is ((15−r)<<4)|r, i.e. 0xF0, 0xE1, ..., 0x4B. It is XORed into x2[7:0] only.
- p^a runs rounds 12−a through 11.
- Substitution: the standard ASCON 5-bit S-box is applied bit-sliced to all 64 columns (x0 is the MSB of each column).
- Diffusion rotation pairs:
  - x0: (19, 28)
  - x1: (61, 39)
  - x2: (1, 6)
  - x3: (10, 17)
  - x4: (7, 41)
- FSM states:
  - IDLE to RUN when `start_i`=1: load `state_i`; set `round_o` to 12−a.
  - RUN to RUN while `round_o` + `UNROLL` < 12: apply `UNROLL` rounds; `round_o` += `UNROLL`.
  - RUN to IDLE on the last step: apply the final rounds; `round_o` becomes 12; `done_o`=1 for one cycle.
- `busy_o` = 1 exactly in RUN.
- `start_i` while `busy_o`=1 is ignored. `mode_i` and `state_i` changes during RUN have no effect.
- `start_i` in the cycle `done_o`=1 is accepted (back-to-back operation).
- With `UNROLL`=2, rounds r and r+1 are chained combinationally within one cycle.
- Reset values: `state_o`=0, `busy_o`=0, `done_o`=0, `round_o`=12, FSM in IDLE.
- Reset mid-operation aborts immediately to the reset values. No `done_o` is produced for the aborted permutation.

## Timing
- E0 is the edge sampling `start_i`=1 in IDLE. Rounds are applied at edges E1..En, with n = a/`UNROLL`.
- `done_o` and the final `state_o` are visible after En.
- Latency from E0 to done edge:
  - p12: 12 edges (`UNROLL`=1), 6 edges (`UNROLL`=2).
  - p8: 8 or 4 edges.
  - p6: 6 or 3 edges.
- Throughput is one permutation per n+1 cycles when restarting on the `done_o` cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Critical path is `UNROLL` x (XOR + S-box + diffusion).

## Configuration
- `ASCON_PERM_BYPASS_EN` defined: `mode_i`=11 is a zero-round bypass.
  - E0 loads `state_i`; `done_o` pulses after E1; `state_o` equals `state_i` unchanged; `round_o` is 12.
- `ASCON_PERM_BYPASS_EN` undefined: `mode_i`=11 is treated as 00 (p12).

## Test plan
- Reset then idle:
  - Stimulus: assert `reset_i` asynchronously mid-cycle.
  - Response: `state_o`=0, `busy_o`=0, `done_o`=0, `round_o`=12 immediately; all hold with `start_i`=0.
- p12 with `UNROLL`=1:
  - Stimulus: `state_i`=0, `mode_i`=00.
  - Response: `busy_o` high for 12 cycles; `done_o` pulses at E12; `state_o` matches the golden model.
  - After E1, `round_o`=1 and `state_o` equals one model round using constant 0xF0.
- p6 and p8 with `UNROLL`=2:
  - Stimulus: random state.
  - Response: `done_o` at E3 (p6) and E4 (p8); results equal the golden model.
  - The first constant applied is 0x96 (p6) and 0xB4 (p8).
- Back-to-back and ignored start:
  - `start_i` held high throughout: a second run begins on the `done_o` cycle with no idle cycle.
  - A `start_i` pulse at E3 of p12 does not alter the result or the timing.
- Reset mid-run:
  - Stimulus: assert `reset_i` at E5 of p12, then release and issue a new start.
  - Response: no `done_o` for the aborted run; the new run completes with correct output 12 edges later.
- Mode 11:
  - Stimulus: `mode_i`=11 with `state_i`=0x0123...
  - Response with `ASCON_PERM_BYPASS_EN`: `done_o` at E1, `state_o`=`state_i`.
  - Response without it: behaves identically to p12.
